// File: rtl/ram_buffer_if.sv
// ram_buffer_if: bus bundle for ram_buffer.
// Ports (master = controller/testbench, slave = ram_buffer):
//   WorI, mode, read_addr, en            read request (1=weight, 0=inference stream)
//   ram_write_en/addr/data               RAM write port
//   ram_output, read_addr_out            registered RAM read data and its address
//   weight_out                           last weight read
//   l_out_0, l_out_1                     registered tails of line buffers 0/1
//   out0..out4, out_valid                skewed window column taps and their valids
interface ram_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
);
    logic                  WorI;
    logic [2:0]            mode;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  en;
    logic                  ram_write_en;
    logic [ADDR_WIDTH-1:0] ram_write_addr;
    logic [DATA_WIDTH-1:0] ram_write_data;
    logic [DATA_WIDTH-1:0] l_out_0;
    logic [DATA_WIDTH-1:0] l_out_1;
    logic [DATA_WIDTH-1:0] out0;
    logic [DATA_WIDTH-1:0] out1;
    logic [DATA_WIDTH-1:0] out2;
    logic [DATA_WIDTH-1:0] out3;
    logic [DATA_WIDTH-1:0] out4;
    logic [4:0]            out_valid;
    logic [ADDR_WIDTH-1:0] read_addr_out;
    logic [DATA_WIDTH-1:0] weight_out;
    logic [DATA_WIDTH-1:0] ram_output;

    modport master (
        output WorI, mode, read_addr, en, ram_write_en, ram_write_addr, ram_write_data,
        input  l_out_0, l_out_1, out0, out1, out2, out3, out4, out_valid,
               read_addr_out, weight_out, ram_output
    );
    modport slave (
        input  WorI, mode, read_addr, en, ram_write_en, ram_write_addr, ram_write_data,
        output l_out_0, l_out_1, out0, out1, out2, out3, out4, out_valid,
               read_addr_out, weight_out, ram_output
    );
endinterface

// File: rtl/ram_buffer.sv
// ram_buffer: 2^ADDR_WIDTH x DATA_WIDTH feature-map/weight RAM with a 4-line
// buffer producing a wavefront-skewed 5-row column for the conv array.
// Ports: clk, rst_n (async active-low), bus (ram_buffer_if.slave: read/write
// requests in, RAM data, weight, line-buffer tails and skewed taps out).
module ram_buffer #(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_WIDTH        = 11,
    parameter int MAX_WIDTH         = 32,
    parameter int FEATURE_MAP1_SIZE = 32,
    parameter int FEATURE_MAP2_SIZE = 28,
    parameter int FEATURE_MAP3_SIZE = 14,
    parameter int FEATURE_MAP4_SIZE = 10,
    parameter int FEATURE_MAP5_SIZE = 5,
    parameter int WAVEFRONT_DELAY   = 4
) (
    input logic        clk,
    input logic        rst_n,
    ram_buffer_if.slave bus
);
    localparam int NT = WAVEFRONT_DELAY + 1;
    // skew chains packed triangularly: tap k owns k+1 stages starting at k*(k+1)/2
    localparam int NP = NT * (NT + 1) / 2;
    localparam int PW = $clog2(MAX_WIDTH * MAX_WIDTH + 1);
    localparam int LW = $clog2(MAX_WIDTH);
    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t mem [2**ADDR_WIDTH];

    word_t                 ram_output_q, ram_output_d;
    logic [ADDR_WIDTH-1:0] read_addr_out_q, read_addr_out_d;
    logic                  rd_v_q, rd_v_d, rd_w_q, rd_w_d;
    word_t                 weight_out_q, weight_out_d;
    logic [2:0]            mode_q, mode_d;
    logic [PW-1:0]         p_q, p_d;
    word_t                 lb_q [NT-1][MAX_WIDTH];
    word_t                 lb_d [NT-1][MAX_WIDTH];
    word_t                 l0_q, l0_d, l1_q, l1_d;
    word_t                 dp_q [NP];
    word_t                 dp_d [NP];
    logic [NP-1:0]         vp_q, vp_d;

    logic [PW-1:0]         w;
    logic [LW-1:0]         wm1;
    logic                  beat;
    word_t                 tap [NT];

    always_ff @(posedge clk)
        if (bus.ram_write_en) mem[bus.ram_write_addr] <= bus.ram_write_data;

    always_comb begin
        w = (bus.mode == 3'd1) ? PW'(FEATURE_MAP2_SIZE) :
            (bus.mode == 3'd2) ? PW'(FEATURE_MAP3_SIZE) :
            (bus.mode == 3'd3) ? PW'(FEATURE_MAP4_SIZE) :
            (bus.mode == 3'd4) ? PW'(FEATURE_MAP5_SIZE) : PW'(FEATURE_MAP1_SIZE);
        wm1 = LW'(w - PW'(1));
        beat = rd_v_q & ~rd_w_q;
        tap[0] = ram_output_q;
        for (int k = 1; k < NT; k++) tap[k] = lb_q[k-1][wm1];
        // read-first: the RAM is sampled here before this edge's write lands
        ram_output_d = bus.en ? mem[bus.read_addr] : ram_output_q;
        read_addr_out_d = bus.en ? bus.read_addr : read_addr_out_q;
        rd_v_d = bus.en;
        rd_w_d = bus.WorI;
        weight_out_d = (rd_v_q & rd_w_q) ? ram_output_q : weight_out_q;
        mode_d = bus.mode;
        p_d = (bus.mode != mode_q || (bus.WorI && bus.en)) ? '0 :
              beat ? ((p_q == w * w - PW'(1)) ? '0 : p_q + PW'(1)) : p_q;
        lb_d = lb_q;
        l0_d = beat ? tap[1] : l0_q;
        l1_d = beat ? tap[2] : l1_q;
        if (beat)
            for (int k = 0; k < NT - 1; k++) begin
                lb_d[k][0] = tap[k];
                for (int j = 1; j < MAX_WIDTH; j++) lb_d[k][j] = lb_q[k][j-1];
            end
        dp_d = dp_q;
        vp_d = '0;
        for (int k = 0; k < NT; k++) begin
            dp_d[k*(k+1)/2] = tap[k];
            vp_d[k*(k+1)/2] = beat && (p_q >= PW'(k) * w);
            for (int j = 1; j <= k; j++) begin
                dp_d[k*(k+1)/2+j] = dp_q[k*(k+1)/2+j-1];
                vp_d[k*(k+1)/2+j] = vp_q[k*(k+1)/2+j-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ram_output_q    <= '0;
            read_addr_out_q <= '0;
            rd_v_q          <= 1'b0;
            rd_w_q          <= 1'b0;
            weight_out_q    <= '0;
            mode_q          <= '0;
            p_q             <= '0;
            lb_q            <= '{default: '0};
            l0_q            <= '0;
            l1_q            <= '0;
            dp_q            <= '{default: '0};
            vp_q            <= '0;
        end else begin
            ram_output_q    <= ram_output_d;
            read_addr_out_q <= read_addr_out_d;
            rd_v_q          <= rd_v_d;
            rd_w_q          <= rd_w_d;
            weight_out_q    <= weight_out_d;
            mode_q          <= mode_d;
            p_q             <= p_d;
            lb_q            <= lb_d;
            l0_q            <= l0_d;
            l1_q            <= l1_d;
            dp_q            <= dp_d;
            vp_q            <= vp_d;
        end

    assign bus.ram_output    = ram_output_q;
    assign bus.read_addr_out = read_addr_out_q;
    assign bus.weight_out    = weight_out_q;
    assign bus.l_out_0       = l0_q;
    assign bus.l_out_1       = l1_q;
    assign bus.out0          = dp_q[0];
    assign bus.out1          = dp_q[2];
    assign bus.out2          = dp_q[5];
    assign bus.out3          = dp_q[9];
    assign bus.out4          = dp_q[14];
    assign bus.out_valid     = {vp_q[14], vp_q[9], vp_q[5], vp_q[2], vp_q[0]};
endmodule

// File: tb/tb_ram_buffer.sv
// tb_ram_buffer: scoreboard bench for ram_buffer against a stream-history model.
module tb_ram_buffer;
    typedef struct {int c; int d; int a;} exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;
    int   v4cnt = 0;

    ram_buffer_if bus();
    ram_buffer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic [7:0] mem_m [1024];
    int   hist[$];
    int   p = 0, prev_mode = 0, cur_mode = 0, pend_val = 0;
    bit   pend_beat = 1'b0, pend_wt = 1'b0;
    exp_t tq[5][$];
    exp_t sq[4][$];
    string nm[4] = '{"ram_output", "weight_out", "l_out_0", "l_out_1"};

    function automatic exp_t mk(int c, int d, int a);
        exp_t x;
        x.c = c; x.d = d; x.a = a;
        return x;
    endfunction

    function automatic int wof(int m);
        return m == 1 ? 28 : m == 2 ? 14 : m == 3 ? 10 : m == 4 ? 5 : 32;
    endfunction

    function automatic void chk(string s, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", s, act, exp, cyc);
        end
    endfunction

    function automatic void miss(string s, int exp, int at);
        checks++;
        errors++;
        $display("FAIL %s: got nothing expected %0d at cycle %0d (cycle %0d)", s, exp, at, cyc);
    endfunction

    // One clock of stimulus; the model advances by the edge these inputs are sampled on.
    task automatic drive(input bit en, input bit wori, input int ra, input bit we, input int wa, input int wd);
        int e, w, n, v;
        e = cyc + 1;
        w = wof(cur_mode);
        bus.en = en; bus.WorI = wori; bus.mode = 3'(cur_mode); bus.read_addr = 11'(ra);
        bus.ram_write_en = we; bus.ram_write_addr = 11'(wa); bus.ram_write_data = 8'(wd);
        if (pend_beat) begin
            hist.push_back(pend_val);
            n = hist.size() - 1;
            for (int k = 0; k < 5; k++)
                if (p >= k * w) tq[k].push_back(mk(e + k, hist[n - k * w], 0));
            if (n >= w) sq[2].push_back(mk(e, hist[n - w], 0));
            if (n >= 2 * w) sq[3].push_back(mk(e, hist[n - 2 * w], 0));
        end
        if (pend_wt) sq[1].push_back(mk(e, pend_val, 0));
        if (cur_mode != prev_mode) begin
            p = 0;
            hist.delete();
        end else if (wori && en) p = 0;
        else if (pend_beat) p = (p + 1) % (w * w);
        prev_mode = cur_mode;
        v = int'(mem_m[ra]);
        if (en) sq[0].push_back(mk(e, v, ra));
        pend_beat = en && !wori;
        pend_wt = en && wori;
        pend_val = v;
        if (we) mem_m[wa] = 8'(wd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_mode(input int m);
        idle(1);
        cur_mode = m;
        idle(1);
    endtask

    always @(negedge clk) if (mon_on) begin
        logic [7:0] outs [5];
        int act [4];
        exp_t x;
        outs = '{bus.out0, bus.out1, bus.out2, bus.out3, bus.out4};
        act[0] = int'(bus.ram_output);
        act[1] = int'(bus.weight_out);
        act[2] = int'(bus.l_out_0);
        act[3] = int'(bus.l_out_1);
        if (bus.out_valid[4]) v4cnt++;
        for (int k = 0; k < 5; k++) begin
            if (bus.out_valid[k]) begin
                if (tq[k].size() == 0) chk($sformatf("spurious out_valid[%0d]", k), 1, 0);
                else begin
                    x = tq[k].pop_front();
                    chk($sformatf("out%0d timing", k), cyc, x.c);
                    chk($sformatf("out%0d data", k), int'(outs[k]), x.d);
                end
            end else if (tq[k].size() != 0 && tq[k][0].c <= cyc) begin
                x = tq[k].pop_front();
                miss($sformatf("out_valid[%0d]", k), x.d, x.c);
            end
        end
        for (int i = 0; i < 4; i++) begin
            while (sq[i].size() != 0 && sq[i][0].c < cyc) begin
                x = sq[i].pop_front();
                miss(nm[i], x.d, x.c);
            end
            if (sq[i].size() != 0 && sq[i][0].c == cyc) begin
                x = sq[i].pop_front();
                chk(nm[i], act[i], x.d);
                if (i == 0) chk("read_addr_out", int'(bus.read_addr_out), x.a);
            end
        end
    end

    initial begin
        bus.en = 0; bus.WorI = 0; bus.mode = 0; bus.read_addr = 0;
        bus.ram_write_en = 0; bus.ram_write_addr = 0; bus.ram_write_data = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ram_output", int'(bus.ram_output), 0);
        chk("reset read_addr_out", int'(bus.read_addr_out), 0);
        chk("reset weight_out", int'(bus.weight_out), 0);
        chk("reset l_out_0", int'(bus.l_out_0), 0);
        chk("reset l_out_1", int'(bus.l_out_1), 0);
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset out0", int'(bus.out0), 0);
        chk("reset out1", int'(bus.out1), 0);
        chk("reset out2", int'(bus.out2), 0);
        chk("reset out3", int'(bus.out3), 0);
        chk("reset out4", int'(bus.out4), 0);
        rst_n = 1'b1;
        mon_on = 1'b1;

        for (int i = 0; i < 1024; i++) drive(0, 0, 0, 1, i, i & 255);
        drive(1, 0, 5, 0, 0, 0);
        idle(3);
        for (int a = 800; a <= 824; a++) drive(1, 1, a, 0, 0, 0);
        idle(3);

        set_mode(4);
        v4cnt = 0;
        for (int a = 0; a < 25; a++) drive(1, 0, a, 0, 0, 0);
        idle(8);
        chk("out_valid[4] beats W=5", v4cnt, 5);

        set_mode(1);
        for (int a = 0; a < 60; a++) drive(1, 0, a, 0, 0, 0);
        idle(8);

        set_mode(0);
        v4cnt = 0;
        for (int a = 0; a < 1024; a++) drive(1, 0, a, 0, 0, 0);
        idle(8);
        chk("out_valid[4] beats W=32", v4cnt, 896);

        drive(1, 0, 7, 1, 7, 8'hAA);
        drive(1, 0, 7, 0, 0, 0);
        idle(4);

        for (int s = 0; s < 6; s++) begin
            set_mode($urandom_range(0, 7));
            for (int i = 0; i < 500; i++)
                drive(($urandom % 10) < 7, (s % 2 == 1) && (($urandom % 10) < 2),
                      $urandom_range(0, 1023), ($urandom % 4) == 0,
                      $urandom_range(0, 1023), $urandom_range(0, 255));
        end
        idle(10);
        for (int k = 0; k < 5; k++) chk($sformatf("undelivered tap %0d", k), tq[k].size(), 0);
        for (int i = 0; i < 4; i++) chk($sformatf("undelivered %s", nm[i]), sq[i].size(), 0);

        mon_on = 1'b0;
        set_mode(0);
        for (int a = 100; a < 140; a++) drive(1, 0, a, 0, 0, 0);
        drive(1, 1, 900, 0, 0, 0);
        drive(1, 1, 901, 0, 0, 0);
        drive(1, 0, 141, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset ram_output", int'(bus.ram_output), 0);
        chk("async reset read_addr_out", int'(bus.read_addr_out), 0);
        chk("async reset weight_out", int'(bus.weight_out), 0);
        chk("async reset l_out_0", int'(bus.l_out_0), 0);
        chk("async reset out0", int'(bus.out0), 0);
        chk("async reset out_valid", int'(bus.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_buffer.md
Name: ram_buffer

Overview:
- Feature-map/weight buffer for the LeNet accelerator.
- A 2048x8 single-clock RAM with a sync write port and a sync read port.
- In weight mode (WorI=1), read data is forwarded to weight_out.
- In inference mode (WorI=0), read data streams row-major through a 4-line buffer. The buffer emits a 5-row vertical column (out0..out4), wavefront-skewed for the downstream systolic conv array, with per-tap valid flags.

Parameters:
- DATA_WIDTH, 8, pixel/weight width
- ADDR_WIDTH, 11, RAM address width; depth = 2^ADDR_WIDTH
- MAX_WIDTH, 32, line buffer length (max feature-map width)
- FEATURE_MAP1_SIZE, 32, width for mode 0
- FEATURE_MAP2_SIZE, 28, width for mode 1
- FEATURE_MAP3_SIZE, 14, width for mode 2
- FEATURE_MAP4_SIZE, 10, width for mode 3
- FEATURE_MAP5_SIZE, 5, width for mode 4
- WAVEFRONT_DELAY, 4, skew of the last tap (tap k skewed by k cycles, k<=WAVEFRONT_DELAY)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- WorI  in  1  1=weight read, 0=inference read
- mode  in  3  feature-map size select: 0..4 -> W = FEATURE_MAP1..5_SIZE; 5..7 behave as 0
- read_addr  in  ADDR_WIDTH  read address
- en  in  1  read enable
- ram_write_en  in  1  write enable
- ram_write_addr  in  ADDR_WIDTH  write address
- ram_write_data  in  DATA_WIDTH  write data
- l_out_0  out  DATA_WIDTH  line buffer 0 tail (stream delayed W beats)
- l_out_1  out  DATA_WIDTH  line buffer 1 tail (delayed 2W beats)
- out0..out4  out  DATA_WIDTH each  window column taps, skewed
- out_valid  out  5  bit k = outk valid
- read_addr_out  out  ADDR_WIDTH  address aligned with ram_output
- weight_out  out  DATA_WIDTH  last weight read
- ram_output  out  DATA_WIDTH  registered RAM read data

Behaviour:
- Async reset: every output, pipeline register, line buffer word, pixel counter and valid bit clears to 0. RAM contents are not cleared.
- Write: when ram_write_en=1, mem[ram_write_addr] <= ram_write_data at the rising edge. Writes are independent of en/WorI.
- Read, stage 1 (edge N with en=1):
  - ram_output <= mem[read_addr]
  - read_addr_out <= read_addr
  - rd_v <= 1, rd_w <= WorI
- With en=0, ram_output and read_addr_out hold, and rd_v <= 0.
- Same-address read and write in one cycle: read-first, ram_output returns the old data.
- Weight path, stage 2 (edge N+1): if rd_v & rd_w, weight_out <= ram_output; otherwise weight_out holds. Latency from address to weight_out is 2 edges.
- Stream beat: a cycle with rd_v & !rd_w. Only beats advance the line buffers and the pixel counter.
- Line buffers: a chain of 4 shift registers LB0..LB3, each W deep (W from the current mode, <= MAX_WIDTH).
  - On a beat, ram_output enters LB0 and each tail feeds the next buffer.
  - Untapped entries beyond W are ignored.
- Column tap k (k=0..4) is the stream delayed k*W beats: tap0 = ram_output, tap k = tail of LB(k-1).
- l_out_0 and l_out_1 are the registered tails of LB0 and LB1, updated on beats.
- Tap validity: pixel counter p (0..W*W-1) counts beats within the frame. Tap k is valid on a beat when p >= k*W.
- Skew: tap k and its valid bit pass through k free-running registers (plus one output register) into outk and out_valid[k].
  - out0 is updated the edge after the beat (latency 2 from address).
  - outk appears k edges later than out0.
- On non-beat cycles the stage-0 valid input is 0, so valid bits drain out of the skew chains.
- Frame end: after beat p=W*W-1, p wraps to 0.
- p also clears whenever mode changes, or whenever WorI=1 with en=1.
- Line buffer data is never cleared except by reset; stale data is masked by out_valid.
- Reset mid-operation clears all pipelines immediately. After release, the first valid output needs fresh reads.

Test Plan:
- Load mem[i]=i[7:0] for i=0..1023 with ram_write_en. Then read addr 5 with WorI=0 -> ram_output=5 and read_addr_out=5 one edge after sampling.
- WorI=1, en=1, addresses 800..824 on consecutive cycles -> weight_out = 32,33,...,56 (800&255=32), 2 edges after each address. out_valid stays 0.
- mode=4 (W=5), stream addresses 0..24:
  - out_valid[0] asserts from beat 0, and out0 follows 0,1,2...
  - out4 first valid carries pixel 20 minus 20 = value 0, 4 cycles after out0 shows 20.
  - out_valid[4] is high for exactly 5 beats.
- mode=1 (W=28) -> l_out_0=0 after beat 28 and 1 after beat 29. l_out_1=0 after beat 56.
- mode=0 (W=32), 1024 beats -> out_valid[4] first asserts 4 edges after out0 shows 128 (=128&255). out4 then shows 0,1,2...
- Simultaneous read and write of the same address with new data 0xAA -> ram_output shows the old value. A read on the next cycle returns 0xAA.
